// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;
  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;
  localparam int CNT_W          = $clog2(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits.
module div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   p,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   p_next,
  output logic         q_bit
);
  logic [W:0] shifted;
  logic [W:0] diff;

  // p[W] is always zero after a restoring step; folding it into the compare keeps
  // the result correct modulo 2^(W+1) even if that invariant were ever broken.
  assign shifted = {p[W-1:0], next_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = p[W] | (shifted >= {1'b0, divisor});
  assign p_next  = q_bit ? diff : shifted;
endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock (DIVIDEND_W cycles);
// divide-by-zero completes at the accepting edge. Result is held until out_ready.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(DIVIDEND_W);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W:0]    p;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    p_next;
  logic                  q_bit;

  div_step #(.W(DIVISOR_W)) u_step (
    .p        (p),
    .next_bit (dvd_sr[DIVIDEND_W-1]),
    .divisor  (dvs),
    .p_next   (p_next),
    .q_bit    (q_bit)
  );

  // dvd_sr shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_sr      <= '0;
      p           <= '0;
      dvs         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dvs      <= divisor;
            dvd_sr   <= dividend;
            p        <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CW'(DIVIDEND_W - 1);
            end
          end
        end
        BUSY: begin
          p      <= p_next;
          dvd_sr <= {dvd_sr[DIVIDEND_W-2:0], q_bit};
          if (cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= {dvd_sr[DIVIDEND_W-2:0], q_bit};
            remainder   <= p_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: results are queued at drive time and
// compared when out_valid rises; scenario tasks check timing and handshake inline.
module tb_seq_restoring_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic seen = 1'b0;

  seq_restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t mk(input logic [31:0] q, input logic [15:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  // Scoreboard consumer: one pop per rising out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !seen) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL score_underflow got q=%h r=%h z=%b with nothing expected", quotient, remainder, div_by_zero);
      end else begin
        e = sb.pop_front();
        if ({quotient, remainder, div_by_zero} !== e) begin
          bad++;
          $display("FAIL score got q=%h r=%h z=%b required q=%h r=%h z=%b",
                   quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
      end
    end
    seen = out_valid;
  end

  task automatic send(input logic [31:0] a, input logic [15:0] b, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid   = 1'b0;
    accept_cyc = cyc;
    dividend   = $urandom;
    divisor    = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL wait_valid_timeout out_valid=%b required=1", out_valid);
    end
    lat = cyc - accept_cyc;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    total += 5;
    if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    if (quotient !== 32'd0)   begin bad++; $display("FAIL reset_quotient got=%h required=0", quotient); end
    if (remainder !== 16'd0)  begin bad++; $display("FAIL reset_remainder got=%h required=0", remainder); end
    if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b required=0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    send(32'd100, 16'd7, mk(32'd14, 16'd2, 1'b0));
    wait_valid(lat);
    total++;
    if (lat != 32) begin bad++; $display("FAIL basic_latency got=%0d required=32", lat); end
    drain();
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_release_valid got=%b required=0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL basic_release_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_boundaries();
    int lat;
    logic [31:0] a [5];
    logic [15:0] b [5];
    exp_t        e [5];
    a[0] = 32'hFFFF_FFFF; b[0] = 16'hFFFF; e[0] = mk(32'h0001_0001, 16'h0000, 1'b0);
    a[1] = 32'h0000_0005; b[1] = 16'h0010; e[1] = mk(32'h0000_0000, 16'h0005, 1'b0);
    a[2] = 32'h0000_0000; b[2] = 16'h0009; e[2] = mk(32'h0000_0000, 16'h0000, 1'b0);
    a[3] = 32'hCAFE_F00D; b[3] = 16'h0001; e[3] = mk(32'hCAFE_F00D, 16'h0000, 1'b0);
    a[4] = 32'h0001_0000; b[4] = 16'hFFFF; e[4] = mk(32'h0000_0001, 16'h0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(a[i], b[i], e[i]);
      wait_valid(lat);
      total++;
      if (lat != 32) begin bad++; $display("FAIL bound%0d_latency got=%0d required=32", i, lat); end
      drain();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    send(32'h1234_5678, 16'h0000, mk(32'hFFFF_FFFF, 16'h5678, 1'b1));
    wait_valid(lat);
    total++;
    if (lat != 0) begin bad++; $display("FAIL dbz_latency got=%0d required=0", lat); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    send(32'd1000000, 16'd37, mk(32'd27027, 16'd1, 1'b0));
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      dividend = $urandom;
      divisor  = 16'($urandom);
      in_valid = i[0];
      @(negedge clk);
      total += 4;
      if (out_valid !== 1'b1)     begin bad++; $display("FAIL hold%0d_valid got=%b required=1", i, out_valid); end
      if (in_ready !== 1'b0)      begin bad++; $display("FAIL hold%0d_ready got=%b required=0", i, in_ready); end
      if (quotient !== 32'd27027) begin bad++; $display("FAIL hold%0d_quotient got=%0d required=27027", i, quotient); end
      if (remainder !== 16'd1)    begin bad++; $display("FAIL hold%0d_remainder got=%0d required=1", i, remainder); end
    end
    in_valid = 1'b0;
    drain();
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b required=0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(32'd200, 16'd9, mk(32'd22, 16'd2, 1'b0));
    wait_valid(lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dividend  = 32'd300;
    divisor   = 16'd7;
    sb.push_back(mk(32'd42, 16'd6, 1'b0));
    @(negedge clk);
    out_ready = 1'b0;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b required=0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL b2b_no_early_accept in_ready=%b required=1", in_ready); end
    @(negedge clk);
    in_valid   = 1'b0;
    accept_cyc = cyc;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept in_ready=%b required=0", in_ready); end
    wait_valid(lat);
    total++;
    if (lat != 32) begin bad++; $display("FAIL b2b_latency got=%0d required=32", lat); end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(32'hDEAD_BEEF, 16'h1234, mk(32'h0, 16'h0, 1'b0));
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b required=0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_ready got=%b required=1", in_ready); end
    if (quotient !== 32'd0) begin bad++; $display("FAIL midrst_quotient got=%h required=0", quotient); end
    if (remainder !== 16'd0) begin bad++; $display("FAIL midrst_remainder got=%h required=0", remainder); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd100, 16'd7, mk(32'd14, 16'd2, 1'b0));
    wait_valid(lat);
    total++;
    if (lat != 32) begin bad++; $display("FAIL midrst_next_latency got=%0d required=32", lat); end
    drain();
  endtask

  task automatic test_random();
    int lat;
    int bad0 = bad;
    logic [15:0] a, b, r;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      r = 16'($urandom_range(0, int'(b) - 1));
      send(32'(a) * 32'(b), b, mk(32'(a), 16'd0, 1'b0));
      wait_valid(lat);
      drain();
      send(32'(a) * 32'(b) + 32'(r), b, mk(32'(a), r, 1'b0));
      wait_valid(lat);
      drain();
    end
    if (bad == bad0) $display("random section: success");
    else             $display("random section: %0d mismatches", bad - bad0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d required=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
